bit_alu: RTL and testbench

- Small registered ALU built from elementary gate functions: OR, AND, NOT, NOR, NAND, pass-through, half-adder add and XOR.
- Sits as a leaf datapath block. A 3-bit opcode selects the function applied to operands a and b.
- The result and a carry flag are registered on the next clock edge, together with a valid strobe.
- The default build is 1 bit wide; wider builds apply the same functions bitwise, with addition as a full-width sum.

---
 rtl/bit_alu_if.sv | 40 ++++
 rtl/bit_alu.sv | 108 ++++++++++
 tb/tb_bit_alu.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bit_alu_if.sv
// Operand/result bundle for bit_alu. The requester drives operands and
// opcode; the ALU returns the registered result, carry and valid strobe.
interface bit_alu_if #(
  parameter int WIDTH = 1
);

  // Request side: operands and function select.
  logic             in_valid;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  // Response side: registered result, carry flag and strobe.
  logic [WIDTH-1:0] res;
  logic             cry;
  logic             out_valid;

  // Requester view.
  modport master (
    output in_valid,
    output opcode,
    output a,
    output b,
    input  res,
    input  cry,
    input  out_valid
  );

  // ALU view.
  modport slave (
    input  in_valid,
    input  opcode,
    input  a,
    input  b,
    output res,
    output cry,
    output out_valid
  );

endinterface

// File: rtl/bit_alu.sv
// bit_alu: registered gate-level ALU. A 3-bit opcode selects OR, AND, NOT,
// NOR, NAND, PASS, ADD or XOR, applied bitwise over WIDTH bits (ADD is a
// full-width unsigned sum, with its carry-out on cry). The result appears
// one clock after an accepted operation together with a one-cycle strobe.
module bit_alu #(
  parameter int WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  bit_alu_if.slave    bus
);

  localparam logic [2:0] OP_OR   = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_PASS = 3'd5;
  localparam logic [2:0] OP_ADD  = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  // Per-function results, all computed in parallel every cycle.
  logic [WIDTH-1:0] or_w;
  logic [WIDTH-1:0] and_w;
  logic [WIDTH-1:0] not_w;
  logic [WIDTH-1:0] nor_w;
  logic [WIDTH-1:0] nand_w;
  logic [WIDTH-1:0] pass_w;
  logic [WIDTH-1:0] xor_w;
  logic [WIDTH-1:0] sum_w;

  // Ripple carry chain; carry_w[0] is tied low because there is no
  // carry-in, and carry_w[WIDTH] is the carry-out of the MSB.
  logic [WIDTH:0]   carry_w;

  // Output registers and their next-state values.
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             cry_q;
  logic             cry_d;
  logic             vld_q;
  logic             vld_d;

  assign carry_w[0] = 1'b0;

  // One slice of gates per bit. Each slice is a full adder built from the
  // same XOR/AND gates the logic functions use; for WIDTH=1 the carry-in is
  // zero, so the slice collapses to a half adder (res=a^b, cry=a&b).
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign or_w[gi]        = bus.a[gi] | bus.b[gi];
      assign and_w[gi]       = bus.a[gi] & bus.b[gi];
      assign not_w[gi]       = ~bus.a[gi];
      assign nor_w[gi]       = ~or_w[gi];
      assign nand_w[gi]      = ~and_w[gi];
      assign pass_w[gi]      = bus.a[gi];
      assign xor_w[gi]       = bus.a[gi] ^ bus.b[gi];
      assign sum_w[gi]       = xor_w[gi] ^ carry_w[gi];
      assign carry_w[gi + 1] = and_w[gi] | (xor_w[gi] & carry_w[gi]);
    end
  endgenerate

  // Next-state selection: an accepted operation loads a new result and
  // clears cry unless it is an ADD; an idle cycle holds res/cry and drops
  // the strobe.
  always_comb begin
    res_d = res_q;
    cry_d = cry_q;
    vld_d = 1'b0;
    if (bus.in_valid) begin
      vld_d = 1'b1;
      cry_d = 1'b0;
      case (bus.opcode)
        OP_OR:   res_d = or_w;
        OP_AND:  res_d = and_w;
        OP_NOT:  res_d = not_w;
        OP_NOR:  res_d = nor_w;
        OP_NAND: res_d = nand_w;
        OP_PASS: res_d = pass_w;
        OP_ADD: begin
          res_d = sum_w;
          cry_d = carry_w[WIDTH];
        end
        OP_XOR:  res_d = xor_w;
        default: res_d = res_q;
      endcase
    end
  end

  // Output register; reset clears everything at once, dropping any
  // operation that was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      cry_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      cry_q <= cry_d;
      vld_q <= vld_d;
    end
  end

  assign bus.res       = res_q;
  assign bus.cry       = cry_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_bit_alu.sv
// Testbench for bit_alu: a WIDTH=1 and a WIDTH=4 instance driven side by
// side, checked against an arithmetic reference model.
module tb_bit_alu;

  logic clk;
  logic rst_n;

  bit_alu_if #(.WIDTH(1)) if1 ();
  bit_alu_if #(.WIDTH(4)) if4 ();

  bit_alu #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  bit_alu #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: expected outputs of each instance.
  int unsigned m_res1 = 0;
  int unsigned m_cry1 = 0;
  int unsigned m_res4 = 0;
  int unsigned m_cry4 = 0;
  int unsigned m_vld  = 0;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {cry at bit 8, result in the low bits}.
  function automatic int unsigned alu_ref(input int unsigned op, input int unsigned x,
                                          input int unsigned y, input int w);
    int unsigned mask;
    int unsigned r;
    int unsigned c;
    int unsigned s;
    mask = (32'd1 << w) - 32'd1;
    r = 0;
    c = 0;
    case (op)
      0: r = x | y;
      1: r = x & y;
      2: r = ~x;
      3: r = ~(x | y);
      4: r = ~(x & y);
      5: r = x;
      6: begin
        s = x + y;
        r = s;
        c = s >> w;
      end
      7: r = x ^ y;
      default: r = 0;
    endcase
    return ((c & 32'd1) << 8) | (r & mask);
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, "_res1"}, 32'(if1.res), m_res1);
    check_eq({tag, "_cry1"}, 32'(if1.cry), m_cry1);
    check_eq({tag, "_vld1"}, 32'(if1.out_valid), m_vld);
    check_eq({tag, "_res4"}, 32'(if4.res), m_res4);
    check_eq({tag, "_cry4"}, 32'(if4.cry), m_cry4);
    check_eq({tag, "_vld4"}, 32'(if4.out_valid), m_vld);
  endtask

  // One transaction: drive, let one edge pass, update model, compare.
  task automatic step(input bit v, input bit [2:0] op, input bit [3:0] av, input bit [3:0] bv);
    int unsigned r;
    if1.in_valid = v;
    if1.opcode   = op;
    if1.a        = av[0];
    if1.b        = bv[0];
    if4.in_valid = v;
    if4.opcode   = op;
    if4.a        = av;
    if4.b        = bv;
    @(posedge clk);
    #1;
    if (v) begin
      r = alu_ref(32'(op), 32'(av[0]), 32'(bv[0]), 1);
      m_res1 = r & 32'hFF;
      m_cry1 = r >> 8;
      r = alu_ref(32'(op), 32'(av), 32'(bv), 4);
      m_res4 = r & 32'hFF;
      m_cry4 = r >> 8;
      m_vld  = 1;
    end else begin
      m_vld = 0;
    end
    check_all("step");
    $display("v=%0d op=%0d a=%h b=%h | w1 res=%0h cry=%0d | w4 res=%h cry=%0d | vld=%0d",
             v, op, av, bv, if1.res, if1.cry, if4.res, if4.cry, if4.out_valid);
  endtask

  int pulses;

  initial begin
    rst_n        = 1'b0;
    if1.in_valid = 1'b0;
    if1.opcode   = '0;
    if1.a        = '0;
    if1.b        = '0;
    if4.in_valid = 1'b0;
    if4.opcode   = '0;
    if4.a        = '0;
    if4.b        = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive sweep (upper bits of the 4-bit operands random).
    for (int op = 0; op < 8; op++) begin
      for (int x = 0; x < 2; x++) begin
        for (int y = 0; y < 2; y++) begin
          step(1'b1, 3'(op), {3'($urandom_range(0, 7)), 1'(x)},
               {3'($urandom_range(0, 7)), 1'(y)});
        end
      end
    end

    // Carry clearing: ADD with a=b=1 sets cry, AND afterwards clears it.
    step(1'b1, 3'd6, 4'hF, 4'h1);
    check_eq("add_carry_w1", 32'(if1.cry), 1);
    check_eq("add_res_w1", 32'(if1.res), 0);
    step(1'b1, 3'd1, 4'hF, 4'h1);
    check_eq("clr_res_w1", 32'(if1.res), 1);
    check_eq("clr_cry_w1", 32'(if1.cry), 0);

    // Hold behaviour: XOR result held across idle cycles.
    step(1'b1, 3'd7, 4'h1, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
      check_eq("hold_res_w1", 32'(if1.res), 1);
      check_eq("hold_cry_w1", 32'(if1.cry), 0);
      check_eq("hold_vld_w1", 32'(if1.out_valid), 0);
    end

    // WIDTH=4 directed cases with literal expectations.
    step(1'b1, 3'd6, 4'hF, 4'h1);
    check_eq("add_wrap_res4", 32'(if4.res), 32'h0);
    check_eq("add_wrap_cry4", 32'(if4.cry), 1);
    step(1'b1, 3'd6, 4'h5, 4'h3);
    check_eq("add_res4", 32'(if4.res), 32'h8);
    check_eq("add_cry4", 32'(if4.cry), 0);
    step(1'b1, 3'd4, 4'hC, 4'hA);
    check_eq("nand_res4", 32'(if4.res), 32'h7);
    step(1'b1, 3'd2, 4'h9, 4'($urandom));
    check_eq("not_res4", 32'(if4.res), 32'h6);

    // Throughput: 16 back-to-back random operations.
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
      if (if1.out_valid && if4.out_valid) pulses++;
    end
    check_eq("throughput_pulses", 32'(pulses), 16);

    // Random mix of valid and idle cycles.
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
    end

    // Mid-stream asynchronous reset.
    if1.in_valid = 1'b1;
    if1.opcode   = 3'd5;
    if1.a        = 1'b1;
    if4.in_valid = 1'b1;
    if4.opcode   = 3'd5;
    if4.a        = 4'hF;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    m_res1 = 0;
    m_cry1 = 0;
    m_res4 = 0;
    m_cry4 = 0;
    m_vld  = 0;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 3'd6, 4'hF, 4'hF);
    step(1'b0, 3'd0, 4'hF, 4'hF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
